// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Holds the fetch FSM encoding, the reset PC default, the empty-slot NOP
// and the layout of a queued {pc, instruction} fetch entry.
package rv_fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          ENTRY_W      = 64;             // pc + instr

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word-align a byte address by clearing the two low bits.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Synchronous FIFO of fetch entries between the fetch PC and decode.
// Latency: an entry written at an edge is readable on dout the next cycle.
// Backpressure: push is dropped when full unless a pop happens in the same
// cycle; flush empties the queue and wins over push (a same-cycle pop is moot).
// Ports: clk/rst, push/pop/flush controls, din/dout entries, count/full/empty.
module ifetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [ENTRY_W-1:0]       din,
  output logic [ENTRY_W-1:0]       dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      rd_ptr_q;
  logic [AW-1:0]      wr_ptr_q;
  logic [CW-1:0]      count_q;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue can still accept when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {32'h0000_0000, NOP_INSTR};
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: drives the zero-latency imem and queues {pc, instr} for decode.
// Latency: a fetched word appears on out_* one cycle after its fetch cycle;
// a redirect target appears two cycles after the redirect cycle.
// Backpressure: fetch stalls (imem_addr holds) while the queue is full and
// decode is not popping. Ports: imem_addr/imem_instr, redirect_*, out_*, fetch_err.
module ifetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic        fetch_err
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          err_q, err_d;

  logic          fetch_en;
  logic          redir;
  logic          misaligned;
  logic          push;
  logic          pop;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic [ENTRY_W-1:0] q_dout;
  fetch_entry_t  head;
  fetch_entry_t  tail_entry;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && redirect_valid && misaligned) begin
      state_d = HALT;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    fetch_en = 1'b0;
    if (state_q == RUN) begin
      fetch_en = 1'b1;
    end
  end

  // ---------------- Datapath ----------------
  assign redir = fetch_en && redirect_valid;
  assign pop   = out_valid && out_ready;
  // Redirect wins over fetch; a full queue only takes a new word if the head leaves.
  assign push  = fetch_en && !redirect_valid && ((q_count < CW'(QDEPTH)) || pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    err_d      = err_q;
    if (redir) begin
      fetch_pc_d = word_align(redirect_pc);
      err_d      = err_q | misaligned;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;  // wraps FFFFFFFC -> 0
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= word_align(RESET_PC);
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      err_q      <= err_d;
    end
  end

  assign tail_entry = '{pc: fetch_pc_q, instr: imem_instr};

  ifetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redir),
    .din  (tail_entry),
    .dout (q_dout),
    .count(q_count),
    .full (q_full),
    .empty(q_empty)
  );

  assign head = fetch_entry_t'(q_dout);

  // Outputs read as zero while the queue is empty so stale slots never leak.
  assign imem_addr = fetch_pc_q;
  assign out_valid = !q_empty;
  assign out_pc    = out_valid ? head.pc    : 32'h0000_0000;
  assign out_instr = out_valid ? head.instr : 32'h0000_0000;
  assign out_pc4   = out_pc + 32'd4;
  assign fetch_err = err_q;

  // A full queue can never also report empty.
  a_full_not_empty : assert property (@(posedge clk) disable iff (rst) q_full |-> !q_empty);

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch initiator for the combinational imem: drives imem addr and captures the returned instruction word.
- Buffers fetched {pc, instruction} pairs in a small queue and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects from execute by flushing the queue and refetching from the new PC.
- Sits between imem and the decode stage of the single-issue core.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- QDEPTH, 2, fetch-queue entries (power of two, >=2).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  fetch address to imem; combinationally equal to fetch_pc.
- imem_instr  input  32  instruction returned by imem, same cycle (zero latency).
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  target PC, sampled when redirect_valid=1.
- out_valid  output  1  queue head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  instruction at the queue head.
- out_pc  output  32  PC of out_instr.
- out_pc4  output  32  out_pc+4, modulo 2^32.
- fetch_err  output  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - fetch_pc=RESET_PC and queue count=0.
  - out_valid=0, out_instr=0, out_pc=0, out_pc4=4.
  - fetch_err=0, state=RUN.
  - imem_addr=RESET_PC in the cycle after reset.
  - Reset overrides all other inputs, including mid-redirect and mid-handshake.
- States:
  - RUN: normal fetching.
  - HALT: no pushes and fetch_pc frozen; entered on a misaligned redirect; left only by rst.
- pop: out_valid && out_ready. The head is removed at the edge; the next entry appears in the following cycle.
- push (RUN, no redirect): when count<QDEPTH, or count==QDEPTH with pop in the same cycle.
  - Writes {fetch_pc, imem_instr} at the tail.
  - fetch_pc <= fetch_pc+4, which wraps 32'hFFFFFFFC -> 0.
- No push: fetch_pc holds.
- Latency: the instruction at fetch_pc is visible on out_* 1 cycle after its push cycle. Throughput is 1 instruction/cycle with out_ready held high.
- Simultaneous push and pop: count unchanged. This is allowed both when full and when count=1.
- Empty with push: out_valid=1 next cycle. Empty without push: out_valid stays 0.
- Redirect (redirect_valid=1 in RUN), with priority over push:
  - A pop in the same cycle is honoured (decode consumed the head).
  - The whole queue is flushed (count <= 0) and there is no push this cycle.
  - fetch_pc <= redirect_pc.
  - out_valid=0 in the next cycle. The first target instruction appears on out_* 2 cycles after the redirect cycle.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - The queue is flushed.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - fetch_err <= 1 (sticky) and state <= HALT.
  - out_valid stays 0 until reset.
- Redirect while in HALT is ignored.
- out_* hold stable while out_valid=1 and out_ready=0.
- fetch_pc[1:0] is always 2'b00.

Decomposition:
- Shared package rv_fetch_pkg holds:
  - fetch state enum {RUN, HALT}.
  - RESET_PC default.
  - NOP encoding 32'h00000013, used as the queue's reset/empty data.
  - the fetch-entry width constant (64 = pc+instr).
- One sub-module, ifetch_queue: synchronous FIFO.
  - Ports: push, pop, flush, din[63:0], dout[63:0], count, full, empty.
  - flush has priority over push, and is honoured together with pop.

Test Plan:
- Sequential fetch from the standard imem image, out_ready=1 after reset:
  - out_* yields pc 0/40000593, then 4/40058593, then 8/0145a803, then C/fe080ee3 on consecutive cycles.
  - First out_valid occurs 1 cycle after the reset release cycle.
- Backpressure:
  - With out_ready=0 for 5 cycles, count saturates at 2 and imem_addr holds at 8.
  - out_pc=0 and out_instr=40000593 stay stable.
  - Releasing out_ready resumes 4, 8, ... with no gap or duplicate.
- Redirect to 32'h000000B4 while the queue is full, with pop in the same cycle:
  - The popped entry is counted as consumed.
  - The next cycle shows out_valid=0.
  - Two cycles later, pc=B4 and instr=407b8bb3; then pc=B8 follows.
- Wrap-around: redirect to 32'hFFFFFFFC gives out_pc=FFFFFFFC, out_pc4=0, and then out_pc=0.
- Misaligned redirect to 32'h00000006:
  - fetch_err=1 and out_valid=0, both held for 10 cycles.
  - imem_addr=4 and frozen; subsequent aligned redirects are ignored.
  - rst clears the unit back to pc 0/40000593.
- Reset mid-stream: asserting rst while out_valid=1 and a redirect is pending gives out_valid=0 next cycle and a restart at RESET_PC.
